// File: rtl/AI_pkg.sv
// Shared types and default sizing for the AI feature writer.
// The writer top optionally builds an overflow counter under AI_FEATURE_WRITER_OVF_CNT_EN.
package AI_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 64;

  localparam logic [7:0] OVF_MAX = 8'hFF;

endpackage

// File: rtl/AI_frame_counter.sv
// Per-frame sample counter; at_end flags that the next increment completes the frame.
module AI_frame_counter #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_inc,
  output logic [ADDR_W:0] o_count,
  output logic            o_at_end
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] TOP  = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] r_count;

  // Clear dominates so a frame restart never leaks a stale increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != TOP)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_end = (r_count == LAST);

endmodule

// File: rtl/ai_feature_writer.sv
// Streams one frame of DEPTH feature samples into a buffer and raises full when done.
// Define AI_FEATURE_WRITER_OVF_CNT_EN to add o_ovf_cnt (in_valid cycles dropped while full).
module ai_feature_writer
  import AI_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count
`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
  ,
  output logic [7:0]        o_ovf_cnt
`endif
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_at_end;
  logic [ADDR_W:0]   w_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  // A coincident init discards the sample on the bus.
  assign w_accept = (r_state == ST_FILL) && i_in_valid && !i_init;

  AI_frame_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_frame_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_init),
    .i_inc    (w_accept),
    .o_count  (w_count),
    .o_at_end (w_at_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_init) begin
      w_state_next = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: if (w_accept && w_at_end) w_state_next = ST_FULL;
        ST_FULL: w_state_next = ST_FULL;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (i_init) begin
        r_wr_addr <= '0;
      end else if (w_accept) begin
        r_wr_addr <= w_count[ADDR_W-1:0];
        r_wr_data <= i_in_data;
      end
    end
  end

  // full is the FULL state itself, so its only falling paths are init and reset.
  assign o_in_ready = (r_state == ST_FILL);
  assign o_full     = (r_state == ST_FULL);
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_count    = w_count;

`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (i_init) begin
      r_ovf_cnt <= '0;
    end else if ((r_state == ST_FULL) && i_in_valid && (r_ovf_cnt != OVF_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`else
  // Overflow counting is compiled out of this build.
`endif

endmodule

// File: tb/tb_ai_feature_writer.sv
// Scoreboard bench for ai_feature_writer: a DEPTH=64 instance and a DEPTH=8 instance.
module tb_ai_feature_writer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        i_init, i_in_valid;
  logic [15:0] i_in_data;
  logic        o_in_ready, o_wr_en, o_full;
  logic [5:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic [6:0]  o_count;

  logic        i8_init, i8_in_valid;
  logic [15:0] i8_in_data;
  logic        o8_in_ready, o8_wr_en, o8_full;
  logic [2:0]  o8_wr_addr;
  logic [15:0] o8_wr_data;
  logic [3:0]  o8_count;

`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
  logic [7:0]  o_ovf_cnt;
  logic [7:0]  o8_ovf_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [21:0] q64[$];
  logic [18:0] q8[$];
  logic [21:0] e64;
  logic [18:0] e8;

  int m_state, m_count, m_ovf;
  int m8_state, m8_count;
  int rise8 = 0;
  logic p8 = 1'b0;

  always #5 clk = ~clk;

  ai_feature_writer #(.DATA_W(16), .DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_init     (i_init),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_in_ready (o_in_ready),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_full     (o_full),
    .o_count    (o_count)
`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
    ,
    .o_ovf_cnt  (o_ovf_cnt)
`endif
  );

  ai_feature_writer #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_init     (i8_init),
    .i_in_valid (i8_in_valid),
    .i_in_data  (i8_in_data),
    .o_in_ready (o8_in_ready),
    .o_wr_en    (o8_wr_en),
    .o_wr_addr  (o8_wr_addr),
    .o_wr_data  (o8_wr_data),
    .o_full     (o8_full),
    .o_count    (o8_count)
`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
    ,
    .o_ovf_cnt  (o8_ovf_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model the DEPTH=64 writer, push expected writes, then advance one cycle and check.
  task automatic drive(input logic ini, input logic vld, input logic [15:0] dat);
    i_init = ini; i_in_valid = vld; i_in_data = dat;
    if (ini) begin
      m_state = 1; m_count = 0; m_ovf = 0;
    end else if (m_state == 1 && vld) begin
      q64.push_back({6'(m_count), dat});
      m_count++;
      if (m_count == 64) m_state = 2;
    end else if (m_state == 2 && vld && m_ovf < 255) begin
      m_ovf++;
    end
    @(posedge clk); #1;
    chk("count", 32'(o_count), 32'(m_count));
    chk("full", 32'(o_full), 32'(m_state == 2));
    chk("in_ready", 32'(o_in_ready), 32'(m_state == 1));
    $display("txn64 init=%0b vld=%0b data=%0h count=%0d full=%0b", ini, vld, dat, o_count, o_full);
  endtask

  task automatic drive8(input logic ini, input logic vld, input logic [15:0] dat);
    i8_init = ini; i8_in_valid = vld; i8_in_data = dat;
    if (ini) begin
      m8_state = 1; m8_count = 0;
    end else if (m8_state == 1 && vld) begin
      q8.push_back({3'(m8_count), dat});
      m8_count++;
      if (m8_count == 8) m8_state = 2;
    end
    @(posedge clk); #1;
    chk("count8", 32'(o8_count), 32'(m8_count));
    chk("full8", 32'(o8_full), 32'(m8_state == 2));
    $display("txn8 init=%0b vld=%0b data=%0h count=%0d full=%0b", ini, vld, dat, o8_count, o8_full);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_wr_en) begin
      if (q64.size() == 0) begin
        chk("unexp_wr64", 32'(o_wr_addr), 32'hFFFF_FFFF);
      end else begin
        e64 = q64.pop_front();
        chk("wr_addr", 32'(o_wr_addr), 32'(e64[21:16]));
        chk("wr_data", 32'(o_wr_data), 32'(e64[15:0]));
        chk("full_at_wr", 32'(o_full), 32'(e64[21:16] == 6'd63));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && o8_wr_en) begin
      if (q8.size() == 0) begin
        chk("unexp_wr8", 32'(o8_wr_addr), 32'hFFFF_FFFF);
      end else begin
        e8 = q8.pop_front();
        chk("wr_addr8", 32'(o8_wr_addr), 32'(e8[18:16]));
        chk("wr_data8", 32'(o8_wr_data), 32'(e8[15:0]));
      end
    end
    if (o8_full && !p8) rise8++;
    p8 = o8_full;
  end

  initial begin
    m_state = 0; m_count = 0; m_ovf = 0;
    m8_state = 0; m8_count = 0;
    rst_n = 1'b0;
    i_init = 0; i_in_valid = 0; i_in_data = '0;
    i8_init = 0; i8_in_valid = 0; i8_in_data = '0;
    #12;
    chk("rst_wr_en", 32'(o_wr_en), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_in_ready", 32'(o_in_ready), 0);
    chk("rst_wr_addr", 32'(o_wr_addr), 0);
    chk("rst_wr_data", 32'(o_wr_data), 0);
    rst_n = 1'b1;

    // Idle: samples without init must be ignored.
    drive(0, 0, 16'h0);
    drive(0, 1, 16'h0007);
    drive(1, 0, 16'h0);
    for (int i = 0; i < 64; i++) drive(0, 1, 16'(i));
    #5;
    chk("sb_empty_frame", 32'(q64.size()), 0);

    for (int i = 0; i < 5; i++) drive(0, 1, 16'(16'h5000 + i));
`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
    chk("ovf_cnt", 32'(o_ovf_cnt), 32'(m_ovf));
`endif

    // Restart after ten samples.
    drive(1, 0, 16'h0);
    for (int i = 0; i < 10; i++) drive(0, 1, 16'(16'h0100 + i));
    drive(1, 0, 16'h0);
    chk("init_wr_addr", 32'(o_wr_addr), 0);
`ifdef AI_FEATURE_WRITER_OVF_CNT_EN
    chk("ovf_cleared", 32'(o_ovf_cnt), 0);
`endif
    drive(0, 1, 16'hAAAA);
    // Init coincident with a sample: sample dropped.
    drive(1, 1, 16'hBEEF);
    drive(0, 1, 16'h1234);
    drive(0, 1, 16'h1235);
    #5;
    chk("sb_empty_restart", 32'(q64.size()), 0);

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(o_wr_en), 0);
    chk("arst_count", 32'(o_count), 0);
    chk("arst_wr_addr", 32'(o_wr_addr), 0);
    chk("arst_wr_data", 32'(o_wr_data), 0);
    chk("arst_in_ready", 32'(o_in_ready), 0);
    m_state = 0; m_count = 0; m_ovf = 0;
    m8_state = 0; m8_count = 0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 1, 16'(16'h7700 + i));
    #5;
    chk("sb_empty_post_rst", 32'(q64.size()), 0);

    // DEPTH=8 with in_valid on every other cycle.
    rise8 = 0;
    drive8(1, 0, 16'h0);
    for (int i = 0; i < 16; i++) drive8(0, (i % 2) == 0, 16'(16'h0800 + i));
    for (int i = 0; i < 4; i++) drive8(0, 1, 16'(16'h0900 + i));
    #5;
    chk("sb_empty8", 32'(q8.size()), 0);
    chk("full8_rises", 32'(rise8), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
